// File: rtl/mul_error_monitor_pkg.sv
// mul_error_monitor_pkg: shared FSM encoding, read-address map and default widths
package mul_error_monitor_pkg;
    localparam int DEF_OPW = 8;
    localparam int DEF_PW  = 15;
    localparam int DEF_CW  = 16;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
    localparam logic [4:0] BIT0        = 5'd0;
    localparam logic [4:0] BIT1        = 5'd1;
    localparam logic [4:0] BIT2        = 5'd2;
    localparam logic [4:0] BIT3        = 5'd3;
    localparam logic [4:0] BIT4        = 5'd4;
    localparam logic [4:0] BIT5        = 5'd5;
    localparam logic [4:0] BIT6        = 5'd6;
    localparam logic [4:0] BIT7        = 5'd7;
    localparam logic [4:0] BIT8        = 5'd8;
    localparam logic [4:0] BIT9        = 5'd9;
    localparam logic [4:0] BIT10       = 5'd10;
    localparam logic [4:0] BIT11       = 5'd11;
    localparam logic [4:0] BIT12       = 5'd12;
    localparam logic [4:0] BIT13       = 5'd13;
    localparam logic [4:0] BIT14       = 5'd14;
    localparam logic [4:0] BIT15       = 5'd15;
    localparam logic [4:0] ADDR_COUNT  = 5'd16;
    localparam logic [4:0] ADDR_SUM    = 5'd17;
    localparam logic [4:0] ADDR_MAX    = 5'd18;
    localparam logic [4:0] ADDR_ERRCNT = 5'd19;
endpackage

// File: rtl/mul_error_monitor_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (!rst_n || clr) q <= '0;
        else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/mul_error_monitor.sv
// mul_error_monitor: compares an approximate multiplier against the exact product
// and accumulates per-bit, count, error-sum and max-error statistics.
module mul_error_monitor
    import mul_error_monitor_pkg::*;
#(
    parameter int OPW = DEF_OPW,
    parameter int PW  = DEF_PW,
    parameter int CW  = DEF_CW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] op_a,
    input  logic [OPW-1:0] op_b,
    input  logic [PW-1:0]  prod_approx,
    input  logic           last,
    output logic           busy,
    output logic           done,
    input  logic [4:0]     rd_addr,
    output logic [31:0]    rd_data
);
    localparam int XW = 2 * OPW;
    state_t         state_q, state_d;
    logic           drain_q, accept, s1_valid;
    logic [XW-1:0]  s1_exact, s1_approx, diff, err;
    logic [15:0]    diff16, err16, max_q;
    logic [CW-1:0]  bit_cnt [16];
    logic [CW-1:0]  count_q, errcnt_q;
    logic [31:0]    sum_q;
    logic [32:0]    sum_n;

    assign in_ready = state_q == ACCUM;
    assign busy     = state_q == ACCUM || state_q == DRAIN;
    assign done     = state_q == DONE;
    assign accept   = in_valid && in_ready && !start;

    always_comb begin
        state_d = state_q;
        if (start) state_d = ACCUM;
        else if (state_q == ACCUM && accept && last) state_d = DRAIN;
        else if (state_q == DRAIN && drain_q) state_d = DONE;
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= state_q == DRAIN && state_d == DRAIN;
        end

    always_ff @(posedge clk)
        if (!rst_n || start) begin
            s1_valid  <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_exact  <= XW'(op_a) * XW'(op_b);
                s1_approx <= XW'(prod_approx);
            end
        end

    assign diff   = s1_exact ^ s1_approx;
    assign err    = s1_exact >= s1_approx ? s1_exact - s1_approx : s1_approx - s1_exact;
    assign diff16 = 16'(diff);
    assign err16  = 16'(err);
    assign sum_n  = {1'b0, sum_q} + 33'(err);

    always_ff @(posedge clk)
        if (!rst_n || start) begin
            sum_q <= '0;
            max_q <= '0;
        end else if (s1_valid) begin
            sum_q <= sum_n[32] ? '1 : sum_n[31:0];
            if (err16 > max_q) max_q <= err16;
        end

    for (genvar k = 0; k < 16; k++) begin : g_bit
        sat_counter #(.W(CW)) u_bit (
            .clk(clk), .rst_n(rst_n), .clr(start), .inc(s1_valid && diff16[k]), .q(bit_cnt[k])
        );
    end

    sat_counter #(.W(CW)) u_count (
        .clk(clk), .rst_n(rst_n), .clr(start), .inc(s1_valid), .q(count_q)
    );
    sat_counter #(.W(CW)) u_errcnt (
        .clk(clk), .rst_n(rst_n), .clr(start), .inc(s1_valid && |diff), .q(errcnt_q)
    );

    assign rd_data = rd_addr <= BIT15        ? 32'(bit_cnt[rd_addr[3:0]]) :
                     rd_addr == ADDR_COUNT  ? 32'(count_q) :
                     rd_addr == ADDR_SUM    ? sum_q :
                     rd_addr == ADDR_MAX    ? 32'(max_q) :
                     rd_addr == ADDR_ERRCNT ? 32'(errcnt_q) : '0;
endmodule

// File: tb/tb_mul_error_monitor.sv
// tb_mul_error_monitor: directed and randomized checks against an arithmetic model
module tb_mul_error_monitor;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, last = 1'b0;
    logic [7:0]  op_a = '0, op_b = '0;
    logic [14:0] prod_approx = '0;
    logic [4:0]  rd_addr = '0;
    logic        in_ready, busy, done;
    logic [31:0] rd_data;
    int checks = 0, failures = 0;

    int unsigned m_bit [16];
    int unsigned m_count, m_err, m_max;
    longint      m_sum;

    mul_error_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .prod_approx(prod_approx), .last(last),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic void m_clear();
        for (int k = 0; k < 16; k++) m_bit[k] = 0;
        m_count = 0; m_err = 0; m_max = 0; m_sum = 0;
    endfunction

    function automatic void m_apply(int a, int b, int p);
        int exact = a * b;
        int d = exact ^ p;
        int e = exact > p ? exact - p : p - exact;
        for (int k = 0; k < 16; k++)
            if (((d >> k) & 1) == 1 && m_bit[k] < 65535) m_bit[k]++;
        if (m_count < 65535) m_count++;
        if (d != 0 && m_err < 65535) m_err++;
        m_sum = (m_sum + e > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sum + e;
        if (e > int'(m_max)) m_max = e;
    endfunction

    function automatic logic [31:0] m_rd(int addr);
        if (addr < 16) return m_bit[addr];
        if (addr == 16) return m_count;
        if (addr == 17) return m_sum[31:0];
        if (addr == 18) return m_max;
        if (addr == 19) return m_err;
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            chk($sformatf("%s_rd%0d", tag, i), rd_data, m_rd(i));
        end
        tick();
    endtask

    task automatic check_flags(string tag, logic r, logic b, logic d);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(r));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_done"}, 32'(done), 32'(d));
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_clear();
    endtask

    task automatic send(int a, int b, int p, logic l);
        op_a = 8'(a); op_b = 8'(b); prod_approx = 15'(p); last = l; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; last = 1'b0;
        m_apply(a, b, p);
    endtask

    task automatic wait_done(string tag);
        int n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done_latency"}, 32'(n), 32'd3);
    endtask

    initial begin
        int a, b, p, n;
        m_clear();
        tick(); tick();
        rst_n = 1'b1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check_all("reset");

        in_valid = 1'b1; op_a = 8'd9; op_b = 8'd9; prod_approx = 15'd1;
        repeat (3) begin
            tick();
            chk("idle_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check_all("idle_hold");

        start_run();
        check_flags("accum", 1'b1, 1'b1, 1'b0);
        send(3, 5, 14, 1'b1);
        wait_done("basic");
        check_flags("basic_done", 1'b0, 1'b0, 1'b1);
        check_all("basic");

        in_valid = 1'b1; op_a = 8'd200; op_b = 8'd7; prod_approx = 15'd3;
        repeat (4) begin
            tick();
            chk("done_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("done_hold", 32'(done), 32'd1);
        check_all("done_hold");

        start_run();
        send(255, 255, 32257, 1'b1);
        wait_done("maxop");
        check_all("maxop");

        start_run();
        send(17, 19, 100, 1'b0);
        op_a = 8'd250; op_b = 8'd250; prod_approx = 15'd0; last = 1'b1; in_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0; last = 1'b0;
        m_clear();
        check_flags("start_prio", 1'b1, 1'b1, 1'b0);
        send(12, 11, 130, 1'b1);
        wait_done("start_discard");
        check_all("start_discard");

        start_run();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: p = (a * b) & 32767;
                1: p = ((a * b) ^ (1 << $urandom_range(0, 14))) & 32767;
                default: p = int'($urandom_range(0, 32767));
            endcase
            send(a, b, p, i == 199);
        end
        wait_done("random");
        check_all("random");

        start_run();
        n = 0;
        for (int x = 224; x <= 255; x++)
            for (int y = 1; y <= x; y++) begin
                send(x, y, (x * y) & 32767, x == 255 && y == 255);
                n++;
            end
        wait_done("sweep");
        chk("sweep_count", m_rd(16), 32'(n));
        check_all("sweep");

        start_run();
        for (int i = 0; i < 65540; i++) send(1, 1, 0, i == 65539);
        wait_done("saturate");
        chk("sat_bit0", m_rd(0), 32'd65535);
        check_all("saturate");

        start_run();
        send(200, 100, 5, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_clear();
        check_flags("mid_reset", 1'b0, 1'b0, 1'b0);
        check_all("mid_reset");
        tick(); tick();
        check_all("mid_reset_later");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_error_monitor.md
MUL_ERROR_MONITOR -- requirements
Module: mul_error_monitor

Interface
REQ-001 Parameter OPW, default 8: operand width of each multiplier input.
REQ-002 Parameter PW, default 15: width of the approximate product under test.
REQ-003 Parameter CW, default 16: width of the per-bit and sample counters.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse; clears statistics and begins accumulation.
REQ-008 in_valid  in  1  sample present on op_a/op_b/prod_approx/last.
REQ-009 in_ready  out  1  monitor accepts a sample this cycle.
REQ-010 op_a, op_b  in  OPW each  operands fed to the multiplier under test.
REQ-011 prod_approx  in  PW  product returned by the multiplier under test.
REQ-012 last  in  1  marks the final sample of a run.
REQ-013 busy  out  1  high in ACCUM and DRAIN.
REQ-014 done  out  1  high in DONE; statistics final.
REQ-015 rd_addr  in  5  statistics read address.
REQ-016 rd_data  out  32  combinational read of the addressed statistic.

Function
REQ-017 The FSM SHALL have states IDLE, ACCUM, DRAIN and DONE.
REQ-018 IDLE->ACCUM and DONE->ACCUM SHALL occur on start; start in any state SHALL clear all statistics and the pipeline.
REQ-019 in_ready SHALL be 1 only in ACCUM; a sample is accepted when in_valid && in_ready.
REQ-020 Accepting a sample with last=1 SHALL move the FSM to DRAIN.
REQ-021 DRAIN SHALL last exactly 2 cycles, then move to DONE.
REQ-022 DONE SHALL hold until start or reset.
REQ-023 Stage 1 SHALL register exact = op_a*op_b (2*OPW bits) and prod_approx zero-extended to 2*OPW bits.
REQ-024 Stage 2 SHALL compute diff = exact XOR approx and err = |exact - approx|.
REQ-025 Stage 2 SHALL update all statistics 2 cycles after acceptance.
REQ-026 Per-bit counter k, k = 0..15, SHALL increment when diff[k]=1.
REQ-027 The sample counter SHALL increment per sample.
REQ-028 The erroneous-sample counter SHALL increment when diff != 0.
REQ-029 The 32-bit sum register SHALL accumulate err.
REQ-030 The 16-bit max register SHALL hold the largest err seen.
REQ-031 All counters and the sum SHALL saturate at all-ones and never wrap.
REQ-032 Read map: addresses 0-15 return the per-bit counters.
REQ-033 Read map: 16 returns the sample count; 17 the sum; 18 the max; 19 the erroneous-sample count.
REQ-034 Read map: addresses 20-31 SHALL return 0.
REQ-035 All read values SHALL be zero-extended to 32 bits.
REQ-036 A start in the same cycle as an accepted sample SHALL discard that sample.
REQ-037 start SHALL take priority over last.

Reset
REQ-038 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-039 Reset SHALL clear all statistics, pipeline valid bits and pipeline data.
REQ-040 Reset values SHALL be in_ready=0, busy=0, done=0 and rd_data=0 for every address.
REQ-041 Reset mid-ACCUM or mid-DRAIN SHALL discard in-flight samples with no partial update.

Structure
REQ-042 A shared package SHALL hold the FSM state encoding, the read-address constants (BIT0..BIT15, ADDR_COUNT=16, ADDR_SUM=17, ADDR_MAX=18, ADDR_ERRCNT=19) and the default OPW/PW/CW.
REQ-043 One sub-module, sat_counter, SHALL be instantiated for each per-bit counter, the sample counter and the erroneous-sample counter.
REQ-044 sat_counter SHALL have a width parameter, clear and inc inputs, and saturate at all-ones.

Verification
REQ-045 Reset, start, then a=3, b=5, prod=14, last=1 -> done after 3 cycles; bit0=1, count=1, sum=1, max=1, errcnt=1.
REQ-046 a=255, b=255, prod=32257, last=1 -> bit15=1, all other bits 0, sum=32768, max=32768.
REQ-047 Full sweep 1<=b<=a<=255 with prod=(a*b) mod 2^15, last on the final pair -> count=32640, bits 0-14 = 0, bit15 = number of pairs with a*b>=32768.
REQ-048 Force bit0 error on 65540 samples -> bit0 counter=65535 (saturated), count=65535.
REQ-049 rst_n low for 1 cycle mid-ACCUM, 1 cycle after acceptance -> FSM in IDLE; all reads 0; no later update from that sample.
REQ-050 start asserted in DONE, then one new sample -> statistics reflect only the new sample.
REQ-051 in_valid held high in IDLE and DONE -> in_ready=0 and statistics unchanged.
